// File: rtl/access_pkg.sv
// access_pkg -- shared constants and types for the access_ctrl keypad lock.
//   PIN_DEFAULT      : default four-digit BCD access code (MS digit first)
//   MAX_FAIL_DEFAULT : default failed-attempt count that triggers lockout
//   ST_*             : FSM state encodings (COLLECT must be all-zero so the
//                      reset-to-0 register cells land in COLLECT)
//   regs_t           : every flop of the controller, packed into one word
package access_pkg;

   localparam logic [15:0] PIN_DEFAULT      = 16'h1234;
   localparam int          MAX_FAIL_DEFAULT = 3;

   localparam logic [2:0] ST_COLLECT = 3'd0;
   localparam logic [2:0] ST_CHECK   = 3'd1;
   localparam logic [2:0] ST_OPEN    = 3'd2;
   localparam logic [2:0] ST_FAIL    = 3'd3;
   localparam logic [2:0] ST_LOCKED  = 3'd4;

   typedef struct packed {
      logic [2:0]  state;
      logic [1:0]  cnt;
      logic [15:0] entry;
      logic        open;
      logic        error;
      logic        locked;
      logic [1:0]  fails;
   } regs_t;

   localparam int REG_W = $bits(regs_t);

   function automatic logic is_bcd(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/access_ctrl_dffr.sv
// DFFR -- single-bit rising-edge D flop with asynchronous active-low reset
// to 0. The only storage cell the controller uses.
//   clk   : clock
//   rst_n : asynchronous reset, active low, forces q to 0
//   d     : data in
//   q     : data out
module DFFR (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= d;
   end

endmodule

// File: rtl/access_ctrl.sv
// access_ctrl -- four-digit keypad access controller with lockout.
//   clk         : clock, all state changes on rising edge
//   rst_n       : asynchronous active-low reset
//   digit_valid : one-cycle strobe qualifying digit
//   digit       : entered BCD digit
//   clear       : abort entry / close door
//   open_o      : access granted (level)
//   error_o     : one-cycle pulse per failed attempt
//   locked_o    : lockout (level, only reset leaves it)
//   fails       : failed attempts since last success or reset
// All outputs come straight from DFFR cells. The output flops are loaded
// from the current state (not the next one), so open_o/error_o appear one
// edge after the FSM enters OPEN/FAIL.
module access_ctrl
   import access_pkg::*;
#(
   parameter logic [15:0] PIN      = PIN_DEFAULT,
   parameter int          MAX_FAIL = MAX_FAIL_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       clear,
   output logic       open_o,
   output logic       error_o,
   output logic       locked_o,
   output logic [1:0] fails
);

   localparam logic [1:0] C_MAX = 2'(MAX_FAIL);

   regs_t             r_q;
   regs_t             w_d;
   logic [REG_W-1:0]  w_q_bits;
   logic [REG_W-1:0]  w_d_bits;
   logic [1:0]        w_fails_inc;

   // Saturating increment; FAIL->LOCKED at MAX means it never actually wraps.
   assign w_fails_inc = (r_q.fails == C_MAX) ? r_q.fails : r_q.fails + 2'd1;

   always_comb begin
      w_d        = r_q;
      w_d.open   = 1'b0;
      w_d.error  = 1'b0;
      w_d.locked = 1'b0;
      case (r_q.state)
         ST_COLLECT: begin
            // clear beats a simultaneous digit
            if (clear) begin
               w_d.cnt = 2'd0;
            end else if (digit_valid) begin
               if (!is_bcd(digit)) begin
                  w_d.state = ST_FAIL;
                  w_d.cnt   = 2'd0;
               end else begin
                  w_d.entry = {r_q.entry[11:0], digit};
                  if (r_q.cnt == 2'd3) begin
                     w_d.state = ST_CHECK;
                     w_d.cnt   = 2'd0;
                  end else begin
                     w_d.cnt = r_q.cnt + 2'd1;
                  end
               end
            end
         end
         ST_CHECK: begin
            w_d.state = (r_q.entry == PIN) ? ST_OPEN : ST_FAIL;
         end
         ST_OPEN: begin
            w_d.fails = 2'd0;
            if (clear) w_d.state = ST_COLLECT;
            else       w_d.open  = 1'b1;
         end
         ST_FAIL: begin
            w_d.error = 1'b1;
            w_d.fails = w_fails_inc;
            if (w_fails_inc == C_MAX) begin
               w_d.state  = ST_LOCKED;
               w_d.locked = 1'b1;
            end else begin
               w_d.state = ST_COLLECT;
            end
         end
         ST_LOCKED: begin
            w_d.locked = 1'b1;
         end
         default: begin
            w_d.state = ST_COLLECT;
         end
      endcase
   end

   assign w_d_bits = w_d;
   assign r_q      = w_q_bits;

   for (genvar i = 0; i < REG_W; i++) begin : g_reg
      DFFR u_ff (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (w_d_bits[i]),
         .q     (w_q_bits[i])
      );
   end

   assign open_o   = r_q.open;
   assign error_o  = r_q.error;
   assign locked_o = r_q.locked;
   assign fails    = r_q.fails;

endmodule

// File: tb/tb_access_ctrl.sv
// tb_access_ctrl -- directed self-checking bench for access_ctrl (default
// PIN 16'h1234, MAX_FAIL 3). Inputs change and outputs are sampled on the
// falling edge.
module tb_access_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       digit_valid;
   logic [3:0] digit;
   logic       clear;
   logic       open_o;
   logic       error_o;
   logic       locked_o;
   logic [1:0] fails;

   int n_assert = 0;
   int n_fail   = 0;

   access_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_valid (digit_valid),
      .digit       (digit),
      .clear       (clear),
      .open_o      (open_o),
      .error_o     (error_o),
      .locked_o    (locked_o),
      .fails       (fails)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // open, error, locked, fails in one go
   task automatic chk_out(input string tag, input logic o, input logic e,
                          input logic l, input logic [1:0] f);
      chk({tag, ".open"},   32'(open_o),   32'(o));
      chk({tag, ".error"},  32'(error_o),  32'(e));
      chk({tag, ".locked"}, 32'(locked_o), 32'(l));
      chk({tag, ".fails"},  32'(fails),    32'(f));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic dig(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      digit_valid = 1'b0;
      digit       = 4'd0;
      clear       = 1'b0;
      tick();
      tick();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
      rst_n = 1'b1;

      // correct code, digit_valid during CHECK and OPEN must be ignored
      dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      chk_out("ok.e0", 1'b0, 1'b0, 1'b0, 2'd0);
      dig(4'd9);                         // FSM in CHECK
      chk_out("ok.e1", 1'b0, 1'b0, 1'b0, 2'd0);
      dig(4'd9);                         // FSM in OPEN
      chk_out("ok.e2", 1'b1, 1'b0, 1'b0, 2'd0);
      tick();
      chk("ok.hold", 32'(open_o), 32'd1);
      do_clear();
      chk_out("ok.clear", 1'b0, 1'b0, 1'b0, 2'd0);
      // a buffered 9 would misalign this entry
      dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      tick(); tick();
      chk("ok.noBuf", 32'(open_o), 32'd1);
      do_clear();

      // three wrong codes -> lockout
      for (int a = 1; a <= 3; a++) begin
         dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd5);
         tick();
         chk("bad.e1.err", 32'(error_o), 32'd0);
         tick();
         chk_out($sformatf("bad%0d.e2", a), 1'b0, 1'b1, (a == 3), 2'(a));
         tick();
         chk_out($sformatf("bad%0d.e3", a), 1'b0, 1'b0, (a == 3), 2'(a));
      end
      // locked: right code and clear do nothing
      dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      tick(); tick(); tick();
      chk_out("locked.pin", 1'b0, 1'b0, 1'b1, 2'd3);
      do_clear();
      chk_out("locked.clr", 1'b0, 1'b0, 1'b1, 2'd3);

      // reset while locked acts immediately
      pulse_reset();
      chk_out("rstLocked", 1'b0, 1'b0, 1'b0, 2'd0);
      release_reset();

      // partial entry then clear, fails stays 0
      dig(4'd1); dig(4'd2);
      do_clear();
      chk("clr.fails", 32'(fails), 32'd0);
      dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      tick(); tick();
      chk_out("clr.open", 1'b1, 1'b0, 1'b0, 2'd0);
      do_clear();

      // non-BCD first digit fails straight away
      dig(4'hA);
      chk("bcd.e0.err", 32'(error_o), 32'd0);
      tick();
      chk_out("bcd.e1", 1'b0, 1'b1, 1'b0, 2'd1);
      // back in COLLECT: correct code opens and clears fails
      dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      tick();
      chk("bcd.keepFails", 32'(fails), 32'd1);
      tick();
      chk_out("bcd.open", 1'b1, 1'b0, 1'b0, 2'd0);

      // reset while OPEN
      pulse_reset();
      chk_out("rstOpen", 1'b0, 1'b0, 1'b0, 2'd0);
      release_reset();

      // reset mid-entry, then full code opens
      dig(4'd1); dig(4'd2);
      pulse_reset();
      chk_out("rstMid", 1'b0, 1'b0, 1'b0, 2'd0);
      release_reset();
      dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      tick(); tick();
      chk_out("rstMid.open", 1'b1, 1'b0, 1'b0, 2'd0);
      do_clear();

      // digit with simultaneous clear is discarded: only 3 digits counted
      clear = 1'b1;
      dig(4'd1);
      clear = 1'b0;
      dig(4'd2); dig(4'd3); dig(4'd4);
      tick(); tick(); tick();
      chk_out("clrDig", 1'b0, 1'b0, 1'b0, 2'd0);
      do_clear();
      dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      tick(); tick();
      chk_out("clrDig.open", 1'b1, 1'b0, 1'b0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
